// File: rtl/arc4_key_search.sv
// Brute-force ARC4 key sequencer: launches the arc4 core per candidate key,
// then scans the decrypted plaintext for printable bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready, waiting for en
// LAUNCH    | waiting for arc4 idle, pulse a4_en
// WAIT_BUSY | waiting for arc4 to drop a4_rdy
// WAIT_DONE | arc4 decrypting; pt_mem port handed to arc4
// RD_LEN    | read pt[0] (two cycles: address, then data)
// CHECK     | pipelined scan of pt[1..L], one byte per cycle
// PASS      | printable text found
// FAIL      | advance to next key or give up at KEY_LAST
// DONE      | ready, key/key_valid hold the result
module arc4_key_search #(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [7:0]  CH_LO     = 8'h20,
    parameter logic [7:0]  CH_HI     = 8'h7E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic [23:0] a4_key,
    input  logic [7:0]  a4_pt_addr,
    input  logic [7:0]  a4_pt_wrdata,
    input  logic        a4_pt_wren,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren,
    input  logic [7:0]  pt_rddata
);
    typedef enum logic [3:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RD_LEN,
        S_CHECK, S_PASS, S_FAIL, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  chk_addr_q, chk_addr_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [7:0]  len_q, len_d;
    logic        cmp_vld_q, cmp_vld_d;
    logic        len_wait_q, len_wait_d;
    logic        byte_bad;
    logic        last_byte;

    // cmp_vld_q: pt_rddata this cycle is the byte at rd_addr_q
    assign byte_bad  = cmp_vld_q && ((pt_rddata < CH_LO) || (pt_rddata > CH_HI));
    assign last_byte = cmp_vld_q && (rd_addr_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= KEY_FIRST;
            key_valid_q <= 1'b0;
            chk_addr_q  <= 8'd0;
            rd_addr_q   <= 8'd0;
            len_q       <= 8'd0;
            cmp_vld_q   <= 1'b0;
            len_wait_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            chk_addr_q  <= chk_addr_d;
            rd_addr_q   <= rd_addr_d;
            len_q       <= len_d;
            cmp_vld_q   <= cmp_vld_d;
            len_wait_q  <= len_wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        chk_addr_d  = chk_addr_q;
        rd_addr_d   = rd_addr_q;
        len_d       = len_q;
        cmp_vld_d   = cmp_vld_q;
        len_wait_d  = len_wait_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (en) begin
                    key_d       = KEY_FIRST;
                    key_valid_d = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH:    if (a4_rdy)  state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!a4_rdy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (a4_rdy) begin
                    chk_addr_d = 8'd0;
                    len_wait_d = 1'b0;
                    state_d    = S_RD_LEN;
                end
            end
            S_RD_LEN: begin
                if (!len_wait_q) begin
                    len_wait_d = 1'b1;
                end else begin
                    len_d = pt_rddata;
                    if (pt_rddata == 8'd0) begin
                        state_d = S_PASS;
                    end else begin
                        chk_addr_d = 8'd1;
                        cmp_vld_d  = 1'b0;
                        state_d    = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (byte_bad) begin
                    chk_addr_d = rd_addr_q;
                    state_d    = S_FAIL;
                end else if (last_byte) begin
                    state_d = S_PASS;
                end else begin
                    rd_addr_d = chk_addr_q;
                    cmp_vld_d = 1'b1;
                    // hold the address at L so nothing past the text is read
                    if (chk_addr_q != len_q) chk_addr_d = chk_addr_q + 8'd1;
                end
            end
            S_PASS: begin
                key_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_FAIL: begin
                if (key_q == KEY_LAST) begin
                    key_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    key_d   = key_q + 24'd1;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy       = (state_q == S_IDLE) || (state_q == S_DONE);
        a4_en     = (state_q == S_LAUNCH) && a4_rdy;
        key       = key_q;
        a4_key    = key_q;
        key_valid = key_valid_q;
        pt_addr   = chk_addr_q;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        if ((state_q == S_LAUNCH) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
            pt_addr   = a4_pt_addr;
            pt_wrdata = a4_pt_wrdata;
            pt_wren   = a4_pt_wren;
        end else if ((state_q == S_CHECK) && byte_bad) begin
            // the next address is already up; fall back so a failing key never reads past its bad byte
            pt_addr = rd_addr_q;
        end
    end
endmodule
